// File: rtl/fifo_rr_arbiter_if.sv
// Producer/FIFO-side bundle for fifo_rr_arbiter: per-requester valid/ready/data plus
// the registered output stage.  slave = arbiter, master = producers + FIFO.
interface fifo_rr_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_ready;
    logic [ID_W-1:0]          grant_id;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, grant_id
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, grant_id
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one registered FIFO write port among NUM_REQ producers.
// Optional macro FIFO_ARB_BURST_EN lets a winner keep priority for up to BURST_LEN transfers.
module fifo_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_rr_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
            $error("fifo_rr_arbiter: NUM_REQ must be within 2..16");
        end
        if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
            $error("fifo_rr_arbiter: BURST_LEN must be within 1..255");
        end
    endgenerate

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     r_ptr;

    logic                w_load;
    logic                w_any;
    logic [ID_W-1:0]     w_winner;
    logic [WIDTH-1:0]    w_win_data;
    logic [NUM_REQ-1:0]  w_req_ready;

`ifdef FIFO_ARB_BURST_EN
    logic [7:0]          r_burst_cnt;
    logic [7:0]          w_burst_nxt;
`endif

    assign w_load = !r_out_valid || bus.out_ready;
    assign w_any  = |bus.req_valid;

    // Distance 0 is the index just after the last grant, so the smallest distance wins.
    always_comb begin
        int v_dist;
        int v_best;
        v_dist   = 0;
        v_best   = NUM_REQ;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_dist = (i + NUM_REQ - 1 - int'(r_ptr)) % NUM_REQ;
            if (bus.req_valid[i] && v_dist < v_best) begin
                v_best   = v_dist;
                w_winner = ID_W'(i);
            end
        end
`ifdef FIFO_ARB_BURST_EN
        if (r_burst_cnt != 8'd0 && bus.req_valid[r_ptr]) begin
            w_winner = r_ptr;
        end
`endif
    end

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == w_winner) begin
                w_win_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Gated by rst so no producer sees an accept while the output stage is held in reset.
    always_comb begin
        w_req_ready = '0;
        if (rst && w_load && w_any) begin
            w_req_ready[w_winner] = 1'b1;
        end
    end

`ifdef FIFO_ARB_BURST_EN
    always_comb begin
        w_burst_nxt = r_burst_cnt;
        if (w_load) begin
            if (!w_any) begin
                w_burst_nxt = 8'd0;
            end else begin
                if (w_winner == r_ptr && r_burst_cnt != 8'd0) begin
                    w_burst_nxt = r_burst_cnt + 8'd1;
                end else begin
                    w_burst_nxt = 8'd1;
                end
                if (w_burst_nxt == 8'(BURST_LEN)) begin
                    w_burst_nxt = 8'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_burst_cnt <= 8'd0;
        end else begin
            r_burst_cnt <= w_burst_nxt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_grant_id  <= '0;
            r_ptr       <= ID_W'(NUM_REQ - 1);
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_win_data;
                r_grant_id  <= w_winner;
                r_ptr       <= w_winner;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.grant_id  = r_grant_id;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed plus randomized bench for fifo_rr_arbiter against a queue-based reference model.
// Burst-mode expectations are compiled in when FIFO_ARB_BURST_EN is defined.
module tb_fifo_rr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_rr_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

    fifo_rr_arbiter #(.WIDTH(W), .NUM_REQ(N), .BURST_LEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // stimulus
    logic [N-1:0] rv;
    logic [W-1:0] d [N];
    logic         ordy;

    // reference model: last grant, output register contents, burst run length, word queue
    int           m_ptr;
    int           m_cnt;
    int           m_gid;
    bit           m_valid;
    logic [W-1:0] m_data;
    logic [W-1:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
`ifdef FIFO_ARB_BURST_EN
        if (m_cnt > 0 && rv[m_ptr]) return m_ptr;
`endif
        for (int k = 1; k <= N; k++) begin
            if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = N - 1;
        m_cnt   = 0;
        m_gid   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        sb.delete();
    endtask

    task automatic drive();
        bus.req_valid = rv;
        for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = d[i];
        bus.out_ready = ordy;
    endtask

    task automatic set_default_data();
        for (int i = 0; i < N; i++) d[i] = 8'hA0 + 8'(i);
    endtask

    // One clock: check combinational ready, scoreboard the drain, advance model, check registers.
    task automatic cycle(input string tag);
        int           w;
        bit           load;
        logic [N-1:0] e_rdy;
        drive();
        #1;
        w     = model_winner();
        load  = !m_valid || ordy;
        e_rdy = '0;
        if (load && w >= 0) e_rdy[w] = 1'b1;
        chk({tag, "/req_ready"}, 32'(bus.req_ready), 32'(e_rdy));
        if (bus.out_valid && ordy) begin
            chk({tag, "/sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) chk({tag, "/sb_order"}, 32'(bus.out_data), 32'(sb.pop_front()));
        end
        if (load) begin
            if (w >= 0) begin
                sb.push_back(d[w]);
`ifdef FIFO_ARB_BURST_EN
                if (w == m_ptr && m_cnt > 0) m_cnt++;
                else m_cnt = 1;
                if (m_cnt >= BL) m_cnt = 0;
`endif
                m_valid = 1'b1;
                m_data  = d[w];
                m_gid   = w;
                m_ptr   = w;
            end else begin
                m_valid = 1'b0;
                m_cnt   = 0;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "/out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        chk({tag, "/out_data"},  32'(bus.out_data),  32'(m_data));
        chk({tag, "/grant_id"},  32'(bus.grant_id),  32'(m_gid));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        model_reset();
        drive();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            chk("rst/out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst/req_ready", 32'(bus.req_ready), 32'd0);
        end
        rst = 1'b1;
    endtask

    initial begin
        set_default_data();
        rv   = '1;
        ordy = 1'b1;

        // 1: reset with all requesters valid, then first grant goes to requester 0
        do_reset(3);
        chk("t1/out_data_rst", 32'(bus.out_data), 32'd0);
        chk("t1/grant_id_rst", 32'(bus.grant_id), 32'd0);
        cycle("t1");
        chk("t1/first_word", 32'(bus.out_data), 32'hA0);
        chk("t1/first_gid",  32'(bus.grant_id), 32'd0);

`ifndef FIFO_ARB_BURST_EN
        // 2: full contention rotates A0..A3 twice
        do_reset(1);
        rv = '1; ordy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle("t2");
            chk("t2/seq", 32'(bus.out_data), 32'hA0 + 32'(k % 4));
        end

        // 3: backpressure holds A1, then A2, A3 follow
        do_reset(1);
        rv = '1; ordy = 1'b1;
        cycle("t3a");
        cycle("t3b");
        chk("t3/loaded", 32'(bus.out_data), 32'hA1);
        ordy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle("t3_stall");
            chk("t3/stall_data", 32'(bus.out_data), 32'hA1);
            chk("t3/stall_rdy",  32'(bus.req_ready), 32'd0);
        end
        ordy = 1'b1;
        cycle("t3c");
        chk("t3/after_a2", 32'(bus.out_data), 32'hA2);
        cycle("t3d");
        chk("t3/after_a3", 32'(bus.out_data), 32'hA3);

        // 4: single requester, then 1001 wrap from ptr=2
        do_reset(1);
        rv = 4'b0100; ordy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle("t4_single");
            chk("t4/gid2", 32'(bus.grant_id), 32'd2);
        end
        rv = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            cycle("t4_wrap");
            chk("t4/wrap", 32'(bus.out_data), (k % 2 == 0) ? 32'hA3 : 32'hA0);
        end
`else
        // 5: bursts of BL per requester, and an early drop hands over to the next
        do_reset(1);
        rv = '1; ordy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cycle("t5");
            chk("t5/burst_seq", 32'(bus.out_data), 32'hA0 + 32'(k / 4));
        end
        do_reset(1);
        rv = '1;
        cycle("t5_drop_a");
        cycle("t5_drop_b");
        chk("t5/two_a0", 32'(bus.out_data), 32'hA0);
        rv = 4'b1110;
        cycle("t5_drop_c");
        chk("t5/handover", 32'(bus.out_data), 32'hA1);
`endif

        // 6: asynchronous reset while the output stage is stalled
        do_reset(1);
        rv = '1; ordy = 1'b1;
        cycle("t6_load");
        ordy = 1'b0;
        drive();
        #2;
        chk("t6/held", 32'(bus.out_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6/async_clear", 32'(bus.out_valid), 32'd0);
        chk("t6/rdy_in_rst",  32'(bus.req_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst  = 1'b1;
        ordy = 1'b1;
        cycle("t6_restart");
        chk("t6/first_gid", 32'(bus.grant_id), 32'd0);

        // random traffic against the model
        do_reset(1);
        for (int k = 0; k < 400; k++) begin
            rv   = N'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) d[i] = W'($urandom);
            cycle("rand");
        end
        rv = '0; ordy = 1'b1;
        cycle("drain_a");
        cycle("drain_b");
        chk("drain/sb_empty", 32'(sb.size()), 32'd0);
        chk("drain/out_valid", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin write arbiter that shares one FIFO write port (`i_data` side of `top`) between `NUM_REQ` producers. Each producer presents data with a valid/ready handshake. The arbiter selects one winner per cycle, registers the winning word into a single output stage, and drives it toward the FIFO under output valid/ready backpressure. It sits directly in front of the FIFO datapath and is the only writer to it.

## Interface
- `WIDTH`, 8, data word width; must match the FIFO `WIDTH`.
- `NUM_REQ`, 4, number of requesters; range 2..16.
- `BURST_LEN`, 4, maximum consecutive grants to one requester; used only with `FIFO_ARB_BURST_EN`; range 1..255.
- Derived: `ID_W = $clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  bit i = requester i has a word.
- `req_data`  in  NUM_REQ*WIDTH  word of requester i in bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NUM_REQ  one-hot or zero; bit i = word i is accepted this cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  WIDTH  registered word to the FIFO.
- `out_ready`  in  1  FIFO accepts the word (not full).
- `grant_id`  out  ID_W  index of the requester whose word is in `out_data`.

## Operation
- Load enable: `load = !out_valid || out_ready`.
- Arbitration is combinational. Among the asserted `req_valid` bits, the winner is the first index found searching `ptr+1, ptr+2, …` modulo `NUM_REQ`, with wrap-around. `ptr` holds the last granted index.
- `req_ready[winner] = load && |req_valid`. All other `req_ready` bits are 0. `req_ready` never asserts for a requester whose `req_valid` is 0.
- On a transfer (`req_valid[i] && req_ready[i]`):
  - `out_data` ← word i
  - `grant_id` ← i
  - `out_valid` ← 1
  - `ptr` ← i
- If `load` is true and no requester is valid, `out_valid` ← 0 and `out_data`/`grant_id` hold their values.
- While `out_valid && !out_ready`:
  - `out_data` and `grant_id` are stable.
  - `out_valid` stays at 1.
  - All `req_ready` bits are 0.
- Simultaneous output drain and new accept in the same cycle is allowed. This gives a throughput of 1 word/cycle.
- No word is dropped or duplicated. Every accepted word appears on the output exactly once.

## Timing
- Reset values (rst = 0, applied immediately):
  - `out_valid` = 0
  - `out_data` = 0
  - `grant_id` = 0
  - `req_ready` = 0
  - `ptr` = NUM_REQ-1, so requester 0 has first priority
  - burst counter = 0
- Reset deassertion is synchronized externally. The first accept can happen on the first rising edge after `rst` rises.
- Latency: a word accepted at edge N is visible on `out_data` with `out_valid` = 1 after edge N. That is one cycle.
- `req_ready` is a combinational function of `req_valid`, `out_valid`, `out_ready`, `ptr` and the burst state. There is no path from `req_data` to `req_ready`.
- Reset mid-operation: a word held in the output register is discarded and priority restarts at requester 0.

## Configuration
- `FIFO_ARB_BURST_EN` defined:
  - After a requester wins, it keeps priority for up to `BURST_LEN` consecutive transfers while its `req_valid` stays high.
  - A 8-bit burst counter counts the transfers.
  - The counter resets to 0 in three cases:
    - the burst holder deasserts valid on a cycle where `load` = 1;
    - a different requester wins;
    - `BURST_LEN` transfers have completed.
  - When `BURST_LEN` transfers complete, normal round-robin resumes from that holder.
  - Backpressure cycles do not advance the counter.
- `FIFO_ARB_BURST_EN` not defined: pure round-robin with no burst counter. The pointer advances after every transfer. `BURST_LEN` is ignored.

## Test plan
Setup for all scenarios: `NUM_REQ`=4, `WIDTH`=8, requester i data = 8'hA0+i.

1. Reset: hold `rst`=0 for 3 cycles with all `req_valid`=1 -> `out_valid`=0 and `req_ready`=4'b0000 throughout. After release, the first accepted word is 8'hA0 with `grant_id`=0.
2. Full contention, macro off: all `req_valid`=1 and `out_ready`=1 for 8 cycles -> `out_data` = A0,A1,A2,A3,A0,A1,A2,A3 on consecutive cycles, and `req_ready` is one-hot each cycle.
3. Backpressure: `out_valid`=1 with `out_data`=A1, then `out_ready`=0 for 4 cycles -> `out_data` stays A1 and `req_ready`=0. After `out_ready`=1, the next words are A2,A3 with no loss or duplicate.
4. Sparse and wrap: only `req_valid[2]`=1 -> `grant_id`=2 every cycle. Then `req_valid`=4'b1001 with `ptr`=2 -> order is A3, A0, A3, A0.
5. Burst, macro on, `BURST_LEN`=4: all valid -> A0×4, A1×4, A2×4, A3×4. If `req_valid[0]` drops after 2 grants, A1 is granted on the next accept.
6. Reset mid-operation: assert `rst`=0 while `out_valid`=1 and `out_ready`=0 -> `out_valid`=0 before the next clock edge. After release, the first grant is requester 0.
